bka_pipe: RTL and testbench
===========================

// Module: bka_pipe
//
// PURPOSE
// Parametrised, pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Generalises the fixed 8-bit combinational BK adder to WIDTH bits, adds carry-in,
// subtract mode, signed overflow and 1..4 register stages. Used in datapaths where
// the full prefix tree does not fit in one cycle.
//
// PARAMETERS
// WIDTH   32  operand width; power of two, 4..64
// STAGES  2   pipeline register stages, 1..4; latency in cycles
//
// PORTS
// clk        in   1      clock, rising edge
// rst        in   1      synchronous reset, active-high
// in_valid   in   1      operand beat valid
// in_ready   out  1      block can accept a beat this cycle
// a          in   WIDTH  operand A
// b          in   WIDTH  operand B
// cin        in   1      carry-in; ignored when sub=1
// sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1)
// out_valid  out  1      result beat valid
// out_ready  in   1      downstream accepts result
// s          out  WIDTH  sum/difference
// cout       out  1      carry-out (sub: 1 = no borrow)
// ovf        out  1      two's-complement signed overflow
//
// BEHAVIOUR
// - Synchronous clk only; rst sampled at rising edge, active-high.
// - Reset: every stage valid bit = 0; out_valid=0, s=0, cout=0, ovf=0. in_ready=1 in
//   the cycle after reset. Reset mid-operation discards all in-flight beats, no output.
// - Operand prep: bb = sub ? ~b : b; c0 = sub ? 1 : cin; p = a^bb; g = a&bb; c0 folded
//   in as generate at bit -1 (g0' = g[0] | p[0]&c0).
// - Prefix: Brent-Kung up-sweep (log2(WIDTH) levels) then down-sweep (log2(WIDTH)-1
//   levels), black cells g=gh|(gl&ph), p=ph&pl. s[i] = p[i] ^ c[i]; c[0]=c0.
// - cout = carry out of bit WIDTH-1; ovf = c[WIDTH-1] ^ cout.
// - Register placement: total prefix levels L = 2*log2(WIDTH)-1; stage k (1..STAGES)
//   registers after level ceil(k*L/STAGES); last stage drives outputs (registered).
//   With STAGES > L, extra stages are pure delay. Output values never combinational
//   from inputs.
// - Handshake: advance = !out_valid | out_ready; in_ready = advance (combinational,
//   no dependence on in_valid). Beat accepted when in_valid & in_ready.
// - When advance=1 all stages shift one position; stage-1 valid <= in_valid.
//   When advance=0 every stage holds data and valid (global stall).
// - Latency: accepted beat appears on outputs exactly STAGES cycles later if no stall;
//   each stall cycle adds one. Throughput 1 beat/cycle with out_ready=1.
// - Bubbles are not squeezed; a bubble at output still stalls only if out_valid=1.
// - out_valid=1 & out_ready=0: s/cout/ovf/out_valid held stable until accepted.
// - Results delivered in acceptance order; no drop, no duplication.
// - Data regs of invalid stages are don't-care but must not be X after reset.
//
// TESTING
// - WIDTH=8,STAGES=2: a=0xFF,b=0x01,cin=0,sub=0 -> after 2 cycles s=0x00,cout=1,ovf=0.
// - WIDTH=8: a=0x7F,b=0x01,sub=0 -> s=0x80,cout=0,ovf=1; a=0x80,b=0x01,sub=1 ->
//   s=0x7F,cout=1,ovf=1; a=0x00,b=0x01,sub=1,cin=0 -> s=0xFF,cout=0,ovf=0.
// - cin carry ripple: a=0xFF,b=0x00,cin=1 -> s=0x00,cout=1; sub=1 with cin=1 ignored.
// - Backpressure: stream 6 beats back-to-back, out_ready=0 for 3 cycles mid-stream ->
//   in_ready=0 during stall, outputs held, all 6 results in order, none lost.
// - Reset with 2 beats in flight -> next cycle out_valid=0, s=0; no stale beats emerge.
// - Random 10k vectors each WIDTH in {4,8,32,64}, STAGES in {1..4}, random
//   in_valid/out_ready vs reference model {cout,s}=a+bb+c0, ovf compare.

Source files
------------

// File: rtl/bka_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// The prefix network is cut into STAGES register slices; the last slice also forms sum/carry/overflow.
module bka_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int LOGW   = $clog2(WIDTH);
  localparam int LEVELS = 2 * LOGW - 1;
  localparam int NMID   = (STAGES > 1) ? STAGES - 1 : 1;

  // g/p are the running group generate/propagate, h the per-bit half-sum kept for the final xor.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] h;
    logic             c0;
  } pfx_t;

  // Last prefix level completed by the end of slice k (slice 0 ends at level 0 = operand prep).
  function automatic int level_end(input int k);
    return (k * LEVELS + STAGES - 1) / STAGES;
  endfunction

  // One Brent-Kung level: levels 1..LOGW are the up-sweep, the rest the down-sweep.
  function automatic pfx_t bk_level(input pfx_t x, input int lv);
    pfx_t y;
    int   step;
    int   half;
    int   j;
    y    = x;
    step = (lv <= LOGW) ? (1 << lv) : (1 << (2 * LOGW - lv));
    half = step / 2;
    for (int i = 0; i < WIDTH; i++) begin
      j = i - half;
      if ((lv <= LOGW && (i + 1) % step == 0) ||
          (lv >  LOGW && i >= step && (i + 1) % step == half)) begin
        y.g[i] = x.g[i] | (x.p[i] & x.g[j]);
        y.p[i] = x.p[i] & x.p[j];
      end
    end
    return y;
  endfunction

  pfx_t             prep;
  pfx_t             stg_in  [STAGES];
  pfx_t             stg_out [STAGES];
  pfx_t             mid_q   [NMID];
  logic             vin     [STAGES];
  logic             vld_q   [STAGES];
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             advance;

  assign out_valid = vld_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  // Carry-in enters the tree as a generate at bit -1, folded into bit 0.
  always_comb begin
    bb          = sub ? ~b : b;
    prep.c0     = sub ? 1'b1 : cin;
    prep.h      = a ^ bb;
    prep.p      = prep.h;
    prep.g      = a & bb;
    prep.g[0]   = prep.g[0] | (prep.h[0] & prep.c0);
  end

  // NOTE: every always_comb output gets a full assignment before any conditional update,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    stg_in[0] = prep;
    vin[0]    = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      stg_in[k] = mid_q[k-1];
      vin[k]    = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      stg_out[k] = stg_in[k];
      for (int lv = 1; lv <= LEVELS; lv++) begin
        if (lv > level_end(k) && lv <= level_end(k + 1))
          stg_out[k] = bk_level(stg_out[k], lv);
      end
    end
  end

  // After the full tree g[i] is the carry into bit i+1; bit 0 takes c0 directly.
  always_comb begin
    carry  = {stg_out[STAGES-1].g[WIDTH-2:0], stg_out[STAGES-1].c0};
    sum_d  = stg_out[STAGES-1].h ^ carry;
    cout_d = stg_out[STAGES-1].g[WIDTH-1];
    ovf_d  = stg_out[STAGES-1].g[WIDTH-2] ^ stg_out[STAGES-1].g[WIDTH-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor and the shift happens in one step.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared too (not only valids) so nothing downstream
      // ever sees X, even though their contents are don't-care while invalid.
      for (int k = 0; k < STAGES; k++) vld_q[k] <= 1'b0;
      for (int k = 0; k < NMID; k++)   mid_q[k] <= '0;
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) vld_q[k] <= vin[k];
      for (int k = 0; k < STAGES - 1; k++) begin
        if (vin[k]) mid_q[k] <= stg_out[k];
      end
      if (vin[STAGES-1]) begin
        s    <= sum_d;
        cout <= cout_d;
        ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_bka_pipe.sv
// Bench for bka_pipe: four width/depth configurations share one stimulus stream,
// each with its own arithmetic reference queue; directed W=8 cases plus random traffic.
module tb_bka_pipe;

  localparam int NCFG = 4;
  localparam int CW [NCFG] = '{8, 64, 4, 32};
  localparam int CS [NCFG] = '{2, 3, 4, 1};

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic cin;
  logic sub;
  logic [63:0] a;
  logic [63:0] b;

  logic [NCFG-1:0]       in_ready_v;
  logic [NCFG-1:0]       out_valid_v;
  logic [NCFG-1:0]       cout_v;
  logic [NCFG-1:0]       ovf_v;
  logic [NCFG-1:0][63:0] s_v;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out [NCFG];
  logic [65:0] exp_q [NCFG][$];
  logic        held  [NCFG];
  logic [65:0] held_v[NCFG];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int W = CW[gi];
    logic [W-1:0] s_w;
    bka_pipe #(.WIDTH(W), .STAGES(CS[gi])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[gi]),
      .a         (a[W-1:0]),
      .b         (b[W-1:0]),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready),
      .s         (s_w),
      .cout      (cout_v[gi]),
      .ovf       (ovf_v[gi])
    );
    assign s_v[gi] = 64'(s_w);
  end

  // Reference: plain integer add of a and the (possibly inverted) b; overflow from operand/result signs.
  function automatic logic [65:0] model(input int w, input logic [63:0] ma, input logic [63:0] mb,
                                        input logic mcin, input logic msub);
    logic [63:0] m;
    logic [63:0] aa;
    logic [63:0] bbv;
    logic [64:0] sum;
    logic        c0;
    logic        co;
    logic        ov;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa  = ma & m;
    bbv = (msub ? ~mb : mb) & m;
    c0  = msub ? 1'b1 : mcin;
    sum = {1'b0, aa} + {1'b0, bbv} + {64'd0, c0};
    co  = sum[w];
    ov  = (aa[w-1] == bbv[w-1]) && (sum[w-1] != aa[w-1]);
    return {ov, co, sum[63:0] & m};
  endfunction

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watches every configuration at the falling edge, where inputs and outputs are stable
  // until the next rising edge that performs the handshakes.
  task automatic monitor();
    logic [65:0] obs;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCFG; i++) begin
        if (rst) begin
          exp_q[i].delete();
          held[i] = 1'b0;
          continue;
        end
        obs = {ovf_v[i], cout_v[i], s_v[i]};
        check($sformatf("in_ready_c%0d", i), 66'(in_ready_v[i]), 66'(!out_valid_v[i] || out_ready));
        if (held[i]) begin
          check($sformatf("hold_valid_c%0d", i), 66'(out_valid_v[i]), 66'(1));
          check($sformatf("hold_data_c%0d", i), obs, held_v[i]);
        end
        held[i] = 1'b0;
        if (out_valid_v[i] === 1'b1) begin
          if (out_ready) begin
            if (exp_q[i].size() == 0)
              check($sformatf("unexpected_out_c%0d", i), 66'(out_valid_v[i]), 66'(0));
            else
              check($sformatf("result_c%0d", i), obs, exp_q[i].pop_front());
            n_out[i]++;
          end else begin
            held[i]   = 1'b1;
            held_v[i] = obs;
          end
        end
        if (in_valid && in_ready_v[i])
          exp_q[i].push_back(model(CW[i], a, b, cin, sub));
      end
    end
  endtask

  // Single beat into idle pipes; checks exact latency of every config and the W=8 result.
  task automatic beat(input logic [63:0] ta, input logic [63:0] tbv, input logic tc, input logic ts,
                      input logic [65:0] exp8, input string tag);
    a = ta; b = tbv; cin = tc; sub = ts;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      for (int i = 0; i < NCFG; i++)
        check($sformatf("%s_lat_c%0d_n%0d", tag, i, n), 66'(out_valid_v[i]), 66'(n == CS[i]));
      if (n == 2) check(tag, {ovf_v[0], cout_v[0], s_v[0]}, exp8);
      tick();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int base;
    int accepted;
    int waited;
    int pending;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      n_out[i] = 0; held[i] = 1'b0; held_v[i] = '0;
    end
    fork
      monitor();
    join_none

    repeat (3) tick();
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("rst_out_valid_c%0d", i), 66'(out_valid_v[i]), 66'(0));
      check($sformatf("rst_result_c%0d", i), {ovf_v[i], cout_v[i], s_v[i]}, 66'(0));
      check($sformatf("rst_in_ready_c%0d", i), 66'(in_ready_v[i]), 66'(1));
    end
    rst = 1'b0;

    // Directed W=8 corner cases: {ovf, cout, s}.
    beat(64'hFF, 64'h01, 1'b0, 1'b0, {1'b0, 1'b1, 64'h00}, "wrap_ff_01");
    beat(64'h7F, 64'h01, 1'b0, 1'b0, {1'b1, 1'b0, 64'h80}, "ovf_add");
    beat(64'h80, 64'h01, 1'b0, 1'b1, {1'b1, 1'b1, 64'h7F}, "ovf_sub");
    beat(64'h00, 64'h01, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFF}, "borrow");
    beat(64'hFF, 64'h00, 1'b1, 1'b0, {1'b0, 1'b1, 64'h00}, "cin_ripple");
    beat(64'h05, 64'h03, 1'b1, 1'b1, {1'b0, 1'b1, 64'h02}, "sub_ignores_cin");

    // Back-to-back stream of 6 beats with a 3-cycle downstream stall mid-stream.
    idx  = 0;
    base = n_out[0];
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 4 && c < 7);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cin = 1'($urandom); sub = 1'($urandom);
      end
      #1;
      if (!out_ready && out_valid_v[0])
        check($sformatf("stall_in_ready_c%0d", c), 66'(in_ready_v[0]), 66'(0));
      accepted = int'(in_valid && in_ready_v[0]);
      tick();
      idx += accepted;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("bp_accepted", 66'(idx), 66'(6));
    check("bp_delivered", 66'(n_out[0] - base), 66'(6));

    // Reset with two beats in flight: nothing may emerge afterwards.
    in_valid = 1'b1;
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321;
    tick();
    a = 64'h0000_0000_0000_0011;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("midrst_out_valid_c%0d", i), 66'(out_valid_v[i]), 66'(0));
      check($sformatf("midrst_s_c%0d", i), 66'(s_v[i]), 66'(0));
    end
    rst  = 1'b0;
    base = n_out[0];
    repeat (8) tick();
    check("midrst_no_stale", 66'(n_out[0] - base), 66'(0));

    // Random traffic with random valid and backpressure.
    for (int cyc = 0; cyc < 12000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom);
      sub = 1'($urandom);
      case ($urandom_range(0, 7))
        0: a = '1;
        1: b = '1;
        2: begin a = '0; b = '1; end
        default: ;
      endcase
      tick();
    end

    // Drain, bounded.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waited    = 0;
    pending   = 1;
    while (pending != 0 && waited < 30) begin
      tick();
      waited++;
      pending = 0;
      for (int i = 0; i < NCFG; i++) pending += exp_q[i].size();
    end
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("drain_empty_c%0d", i), 66'(exp_q[i].size()), 66'(0));
      check($sformatf("drained_some_c%0d", i), 66'(n_out[i] > 3000), 66'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
